// File: rtl/ext_irq_conditioner.sv
// External interrupt conditioner: per-line synchronise, RTC-tick debounce,
// and level or latched rising-edge presentation to the SoC, with a clear port.
module ext_irq_conditioner #(
  parameter int NumIrq        = 4,
  parameter int SyncStages    = 2,
  parameter int DebounceTicks = 3,
  localparam int CntWidth     = $clog2(DebounceTicks + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rtc_i,
  input  logic [NumIrq-1:0] irq_i,
  input  logic [NumIrq-1:0] enable_i,
  input  logic [NumIrq-1:0] edge_mode_i,
  input  logic              clear_valid_i,
  input  logic [NumIrq-1:0] clear_mask_i,
  output logic              clear_ready_o,
  output logic [NumIrq-1:0] irq_o,
  output logic [NumIrq-1:0] pending_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceTicks - 1);

  logic [SyncStages-1:0]             rtc_sync_r;
  logic                              rtc_q_r;
  logic [NumIrq-1:0][SyncStages-1:0] irq_sync_r;
  logic [CntWidth-1:0]               cnt_r [NumIrq];
  logic [NumIrq-1:0]                 stable_r;
  logic [NumIrq-1:0]                 rise_r;
  logic [NumIrq-1:0]                 pending_r;
  logic [NumIrq-1:0]                 irq_r;
  logic                              init_r;
  logic                              ready_r;

  logic                              tick_s;
  logic [NumIrq-1:0]                 irq_s;
  logic [NumIrq-1:0]                 clr_s;
  logic [NumIrq-1:0]                 pending_next_s;
  logic [NumIrq-1:0]                 irq_next_s;

  // Input synchronisers and the RTC edge reference register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rtc_sync_r <= '0;
      rtc_q_r    <= 1'b0;
      irq_sync_r <= '0;
    end else begin
      rtc_sync_r <= {rtc_sync_r[SyncStages-2:0], rtc_i};
      rtc_q_r    <= rtc_sync_r[SyncStages-1];
      for (int k = 0; k < NumIrq; k++) begin
        irq_sync_r[k] <= {irq_sync_r[k][SyncStages-2:0], irq_i[k]};
      end
    end
  end

  // Tick, synchronised lines, and next-state for pending/irq outputs.
  always_comb begin
    tick_s = rtc_sync_r[SyncStages-1] & ~rtc_q_r;
    for (int k = 0; k < NumIrq; k++) begin
      irq_s[k] = irq_sync_r[k][SyncStages-1];
    end
    clr_s          = {NumIrq{clear_valid_i & ready_r}} & clear_mask_i;
    // A rise in the same cycle as a clear re-sets the bit, so no edge is lost.
    pending_next_s = edge_mode_i & (rise_r | (pending_r & ~clr_s));
    irq_next_s     = enable_i & ((edge_mode_i & pending_r) | (~edge_mode_i & stable_r));
  end

  // Debounce: a differing value must persist across DebounceTicks ticks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_r <= '0;
      rise_r   <= '0;
      for (int k = 0; k < NumIrq; k++) begin
        cnt_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumIrq; k++) begin
        if (irq_s[k] == stable_r[k]) begin
          cnt_r[k]  <= '0;
          rise_r[k] <= 1'b0;
        end else if (tick_s && (cnt_r[k] == CntMax)) begin
          stable_r[k] <= irq_s[k];
          cnt_r[k]    <= '0;
          rise_r[k]   <= irq_s[k];
        end else if (tick_s) begin
          cnt_r[k]  <= cnt_r[k] + CntWidth'(1);
          rise_r[k] <= 1'b0;
        end else begin
          rise_r[k] <= 1'b0;
        end
      end
    end
  end

  // Pending bits, conditioned outputs and the clear-port ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_r <= '0;
      irq_r     <= '0;
      init_r    <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      irq_r     <= irq_next_s;
      init_r    <= 1'b1;
      ready_r   <= init_r;
    end
  end

  assign irq_o         = irq_r;
  assign pending_o     = pending_r;
  assign clear_ready_o = ready_r;

endmodule

// File: tb/tb_ext_irq_conditioner.sv
// Randomised scoreboard bench for ext_irq_conditioner against a history-based
// reference model of the conditioning rules.
module tb_ext_irq_conditioner;
  localparam int NumIrq        = 4;
  localparam int SyncStages    = 2;
  localparam int DebounceTicks = 3;
  localparam int MaxCyc        = 8192;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              rtc_i = 1'b0;
  logic [NumIrq-1:0] irq_i = '0;
  logic [NumIrq-1:0] enable_i = '0;
  logic [NumIrq-1:0] edge_mode_i = '0;
  logic              clear_valid_i = 1'b0;
  logic [NumIrq-1:0] clear_mask_i = '0;
  logic              clear_ready_o;
  logic [NumIrq-1:0] irq_o;
  logic [NumIrq-1:0] pending_o;

  always #5 clk = ~clk;

  ext_irq_conditioner #(
    .NumIrq(NumIrq), .SyncStages(SyncStages), .DebounceTicks(DebounceTicks)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .rtc_i(rtc_i), .irq_i(irq_i),
    .enable_i(enable_i), .edge_mode_i(edge_mode_i),
    .clear_valid_i(clear_valid_i), .clear_mask_i(clear_mask_i),
    .clear_ready_o(clear_ready_o), .irq_o(irq_o), .pending_o(pending_o)
  );

  typedef struct packed {
    logic [NumIrq-1:0] irq;
    logic [NumIrq-1:0] pend;
    logic              ready;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw samples per clock edge, plus abstract line state.
  logic [NumIrq-1:0] irq_at [MaxCyc];
  logic              rtc_at [MaxCyc];
  int                cyc = 0;
  int                last_rst = 0;
  logic [NumIrq-1:0] m_stable = '0, m_rise = '0, m_pending = '0, m_irq = '0;
  logic              m_ready = 1'b0;
  int                m_ticks [NumIrq];

  // Synchronised view after edge n: the sample taken SyncStages-1 edges earlier,
  // or zero if that sample predates the last reset.
  function automatic logic [NumIrq-1:0] s_at(int n);
    if (n - SyncStages + 1 > last_rst) return irq_at[n-SyncStages+1];
    return '0;
  endfunction

  function automatic logic rtc_s_at(int n);
    if (n - SyncStages + 1 > last_rst) return rtc_at[n-SyncStages+1];
    return 1'b0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  initial begin
    for (int k = 0; k < NumIrq; k++) m_ticks[k] = 0;
    forever begin
      logic [NumIrq-1:0] s, acc, clr, nxt_irq, nxt_pend;
      logic              tick;
      exp_t              e;
      @(posedge clk);
      cyc++;
      if (cyc >= MaxCyc) begin
        $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MaxCyc);
        $fatal(1, "cycle budget exhausted");
      end
      irq_at[cyc] = irq_i;
      rtc_at[cyc] = rtc_i;
      if (rst_i) begin
        last_rst  = cyc;
        m_stable  = '0; m_rise = '0; m_pending = '0; m_irq = '0; m_ready = 1'b0;
        for (int k = 0; k < NumIrq; k++) m_ticks[k] = 0;
      end else begin
        s    = s_at(cyc - 1);
        tick = rtc_s_at(cyc - 1) & ~rtc_s_at(cyc - 2);
        nxt_irq  = enable_i & ((edge_mode_i & m_pending) | (~edge_mode_i & m_stable));
        clr      = (clear_valid_i && m_ready) ? clear_mask_i : '0;
        nxt_pend = edge_mode_i & (m_rise | (m_pending & ~clr));
        acc = '0;
        for (int k = 0; k < NumIrq; k++) begin
          if (s[k] != m_stable[k]) begin
            if (tick) m_ticks[k]++;
            if (m_ticks[k] >= DebounceTicks) begin
              acc[k]     = 1'b1;
              m_ticks[k] = 0;
            end
          end else begin
            m_ticks[k] = 0;
          end
        end
        m_rise    = acc & s;
        m_stable  = m_stable ^ acc;
        m_pending = nxt_pend;
        m_irq     = nxt_irq;
        m_ready   = (cyc - last_rst >= 2);
      end
      e.irq = m_irq; e.pend = m_pending; e.ready = m_ready;
      exp_q.push_back(e);
    end
  end

  // Monitor: every cycle the DUT presents a fresh output set.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("irq_o", 32'(irq_o), 32'(e.irq));
        chk("pending_o", 32'(pending_o), 32'(e.pend));
        chk("clear_ready_o", 32'(clear_ready_o), 32'(e.ready));
      end
    end
  end

  // RTC reference: period 20 clk.
  initial begin
    forever begin
      repeat (10) @(posedge clk);
      #1 rtc_i = ~rtc_i;
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit found;
    step(3);
    rst_i = 1'b0;
    enable_i = 4'b1111;
    step(2);

    // Level mode: raise and drop line 0.
    irq_i[0] = 1'b1; step(80);
    irq_i[0] = 1'b0; step(80);

    // Glitches on line 1 never reach the output.
    irq_i[1] = 1'b1; step(5);
    irq_i[1] = 1'b0; step(10);
    irq_i[1] = 1'b1; step(30);
    irq_i[1] = 1'b0; step(60);
    chk("glitch_irq1", 32'(irq_o[1]), 32'd0);

    // Edge mode on line 2, then a software clear.
    edge_mode_i[2] = 1'b1;
    irq_i[2] = 1'b1; step(80);
    irq_i[2] = 1'b0; step(20);
    chk("edge_pend2", 32'(pending_o[2]), 32'd1);
    chk("edge_irq2", 32'(irq_o[2]), 32'd1);
    clear_valid_i = 1'b1; clear_mask_i = 4'b0100;
    step(1);
    clear_valid_i = 1'b0; clear_mask_i = 4'b0000;
    chk("clr_pend2", 32'(pending_o[2]), 32'd0);
    chk("clr_irq2_lag", 32'(irq_o[2]), 32'd1);
    step(1);
    chk("clr_irq2", 32'(irq_o[2]), 32'd0);

    // Clear line 3 in the very cycle its rise fires: the set must win.
    edge_mode_i[3] = 1'b1;
    irq_i[3] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1);
      if (m_rise[3]) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL rise3_wait: got no rise expected rise within 300 cycles");
    end
    clear_valid_i = 1'b1; clear_mask_i = 4'b1000;
    step(1);
    clear_valid_i = 1'b0; clear_mask_i = 4'b0000;
    chk("set_wins3", 32'(pending_o[3]), 32'd1);
    irq_i[3] = 1'b0; step(5);

    // Disabled level line still debounces; enabling shows it at once.
    enable_i[0] = 1'b0;
    irq_i[0] = 1'b1; step(90);
    chk("disabled_irq0", 32'(irq_o[0]), 32'd0);
    enable_i[0] = 1'b1; step(1);
    chk("enabled_irq0", 32'(irq_o[0]), 32'd1);

    // Reset mid-debounce with only line 2 pending.
    clear_valid_i = 1'b1; clear_mask_i = 4'b1000; step(1);
    clear_valid_i = 1'b0; clear_mask_i = 4'b0000;
    irq_i[2] = 1'b1; step(80);
    irq_i[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1);
      if (m_ticks[0] == 2) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL cnt0_wait: got no count of 2 expected within 200 cycles");
    end
    chk("pre_rst_pend", 32'(pending_o), 32'h4);
    rst_i = 1'b1; step(1);
    rst_i = 1'b0;
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_pend", 32'(pending_o), 32'd0);
    chk("rst_ready0", 32'(clear_ready_o), 32'd0);
    step(1);
    chk("rst_ready1", 32'(clear_ready_o), 32'd0);
    step(1);
    chk("rst_ready2", 32'(clear_ready_o), 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      step(1);
      rst_i = 1'b0;
      clear_valid_i = 1'b0;
      if ($urandom_range(0, 39) == 0) irq_i[$urandom_range(0, NumIrq-1)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0) enable_i = NumIrq'($urandom);
      if ($urandom_range(0, 149) == 0) edge_mode_i = NumIrq'($urandom);
      if (m_ready && $urandom_range(0, 14) == 0) begin
        clear_valid_i = 1'b1;
        clear_mask_i  = NumIrq'($urandom);
      end
      if ($urandom_range(0, 599) == 0) rst_i = 1'b1;
    end
    rst_i = 1'b0; clear_valid_i = 1'b0;
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ext_irq_conditioner.md
Name: ext_irq_conditioner

Overview:
Conditions the asynchronous external interrupt lines before they reach the SoC external-IRQ input. Per line, the block:
- synchronises the input into the system clock domain;
- debounces it against the RTC (a slow tick, rising edges only);
- presents it to the SoC either as a level or as a latched rising-edge pending bit.

Pending bits are cleared by software through a valid/ready clear port driven from a register file.

Parameters:
NumIrq, 4, number of external interrupt lines.
SyncStages, 2, flip-flop depth of each input synchroniser (rtc_i and every irq_i bit); minimum 2.
DebounceTicks, 3, consecutive RTC ticks a new input value must hold before it is accepted; minimum 1.
CntWidth, $clog2(DebounceTicks+1), debounce counter width (derived, not overridable).

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous active-high reset
rtc_i  input  1  asynchronous RTC reference clock, sampled as data
irq_i  input  NumIrq  asynchronous raw interrupt lines
enable_i  input  NumIrq  per-line output enable
edge_mode_i  input  NumIrq  per-line mode: 1 = rising-edge latched, 0 = level
clear_valid_i  input  1  clear request valid
clear_mask_i  input  NumIrq  pending bits to clear
clear_ready_o  output  1  clear request accepted when high together with valid
irq_o  output  NumIrq  conditioned interrupts to SoC
pending_o  output  NumIrq  raw latched pending bits, edge-mode lines only

Behaviour:
- One clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - all synchroniser flops 0;
  - rtc_q 0;
  - stable[] 0, cnt[] 0, pending[] 0;
  - irq_o 0, pending_o 0, clear_ready_o 0.
- rtc_i tick:
  - rtc_i passes through a SyncStages synchroniser into register rtc_q.
  - tick = sync_rtc & ~rtc_q, a one-clk_i pulse per RTC rising edge.
  - The first cycle after reset cannot tick, because rtc_q starts at 0 and the synchroniser is still being flushed.
- Per-line debounce, on every clk_i:
  - If s (synchronised irq_i bit) == stable: cnt <= 0.
  - Else if tick and cnt == DebounceTicks-1: stable <= s, cnt <= 0.
  - Else if tick: cnt <= cnt+1.
  - Else: cnt holds.
  - Effect: a glitch that reverts before DebounceTicks ticks is discarded, and the counter restarts on every reversal.
  - cnt never exceeds DebounceTicks-1; no wrap.
- Rising-edge detect: rise = stable transitions 0->1, registered so it is a one-cycle pulse in the cycle after stable updates.
- Pending, edge-mode lines only:
  - Set on rise.
  - Cleared when clear_valid_i & clear_ready_o & clear_mask_i[k].
  - If set and clear occur in the same cycle, set wins: the new edge is never lost.
  - Level-mode lines: pending is forced to 0 and clear_mask bits are ignored.
  - Switching edge_mode_i from 1 to 0 clears pending on the next cycle.
- irq_o, registered:
  - Edge mode: irq_o[k] <= enable_i[k] & pending[k].
  - Level mode: irq_o[k] <= enable_i[k] & stable[k].
  - A disabled line still debounces and latches pending; it only gates the output.
- pending_o = pending, registered value.
- Clear handshake:
  - clear_ready_o is 1 in every cycle except the reset cycle and the first cycle after rst_i deasserts.
  - A request is consumed in exactly one cycle; the master must hold valid until ready is high.
  - The clear takes effect on pending at the next clock edge, and on irq_o one cycle after that.
- Latency, irq_i edge to irq_o:
  - SyncStages cycles to reach s, plus the time to accumulate DebounceTicks ticks, plus 1 cycle (stable -> rise/pending, level mode: stable -> irq_o), plus 1 cycle to irq_o.
  - Edge mode: 2 cycles from stable to irq_o.
- Reset mid-operation: asserting rst_i in any cycle, including mid-debounce or during a clear handshake, returns every register to its reset value on that edge. Nothing from the prior state is retained.

Test Plan:
1. Default params. Raise irq_i[0] and hold; edge_mode=0, enable=1; RTC period 20 clk -> irq_o[0] rises after 3 rtc rising edges plus 1 cycle (about 60-62 clk). Drop irq_i[0] -> irq_o[0] falls after 3 more ticks plus 1 cycle.
2. irq_i[1] glitch high for 5 clk, then low, then high for 1.5 RTC periods, then low -> irq_o[1] stays 0 throughout; cnt[1] returns to 0 after each reversal.
3. Edge mode on line 2. Raise irq_i[2] until debounced, then drop -> irq_o[2]=1 and pending_o[2]=1 persist after the input falls. Send clear_valid=1 with mask=4'b0100 -> pending_o[2]=0 the next cycle, irq_o[2]=0 one cycle later.
4. Line 3 in edge mode. Schedule the clear with mask=4'b1000 in the exact cycle rise[3] fires -> pending_o[3] remains 1.
5. enable_i=0 on line 0 in level mode with the input debounced high -> irq_o[0]=0. Set enable_i[0]=1 -> irq_o[0]=1 on the next cycle with no new debounce.
6. Assert rst_i for 1 cycle while cnt[0]=2 and pending_o=4'b0100 -> all outputs are 0 on the next cycle; clear_ready_o=0 for 1 further cycle, then 1; debounce restarts from cnt=0.
